// File: rtl/pipe_pkg.sv
// Shared definitions for processor pipeline stage registers.
package pipe_pkg;

  localparam int CTRL_W = 17;
  localparam int DATA_W = 189;

  typedef logic [CTRL_W-1:0] pipe_ctrl_t;

  // Control word of a stage slot that carries no instruction (NOP).
  localparam pipe_ctrl_t BUBBLE_CTRL = '0;

  // Register-read -> execute payload field widths.
  localparam int RA_W       = 4;
  localparam int RB_W       = 4;
  localparam int DATA_A_W   = 32;
  localparam int DATA_B_W   = 32;
  localparam int OFF21_W    = 32;
  localparam int OFFSTORE_W = 32;
  localparam int ROBJ_W     = 4;
  localparam int IMM_W      = 32;
  localparam int USED_W     = RA_W + RB_W + DATA_A_W + DATA_B_W + OFF21_W
                            + OFFSTORE_W + ROBJ_W + IMM_W;
  // The named fields occupy 172 bits; the rest of the 189-bit payload is spare.
  localparam int SPARE_W    = DATA_W - USED_W;

  // Field offsets (LSB position inside the payload).
  localparam int RA_LSB       = 0;
  localparam int RB_LSB       = RA_LSB + RA_W;
  localparam int DATA_A_LSB   = RB_LSB + RB_W;
  localparam int DATA_B_LSB   = DATA_A_LSB + DATA_A_W;
  localparam int OFF21_LSB    = DATA_B_LSB + DATA_B_W;
  localparam int OFFSTORE_LSB = OFF21_LSB + OFF21_W;
  localparam int ROBJ_LSB     = OFFSTORE_LSB + OFFSTORE_W;
  localparam int IMM_LSB      = ROBJ_LSB + ROBJ_W;

  // Packed view of the reg->exe payload; Ra sits in the least significant bits.
  typedef struct packed {
    logic [SPARE_W-1:0]    spare;
    logic [IMM_W-1:0]      imm;
    logic [ROBJ_W-1:0]     robj;
    logic [OFFSTORE_W-1:0] off_store;
    logic [OFF21_W-1:0]    off21;
    logic [DATA_B_W-1:0]   dat_b;
    logic [DATA_A_W-1:0]   dat_a;
    logic [RB_W-1:0]       rb;
    logic [RA_W-1:0]       ra;
  } regexe_payload_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up on i_inc, stick at all-ones, clear has priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// flush and bubble insertion. in_ready is a pure register output.
module pipe_stage_skid #(
  parameter int                CTRL_W      = pipe_pkg::CTRL_W,
  parameter int                DATA_W      = pipe_pkg::DATA_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Main entry: its ctrl/data registers are the output registers themselves.
  logic              r_main_v;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_data;
  // Skid entry: absorbs the one input accepted while main is stalled.
  logic              r_skid_v;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;

  logic              w_accept;
  logic              w_send;
  logic              w_stall;
  logic              w_main_v;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic              w_skid_v;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  assign w_accept = in_valid && r_in_ready;
  assign w_send   = r_main_v && out_ready;
  assign w_stall  = r_main_v && !out_ready && !flush;

  // Next-state of main and skid entries; flush empties both and drops input.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would infer a latch.
    w_main_v    = r_main_v;
    w_main_ctrl = r_out_ctrl;
    w_main_data = r_out_data;
    w_skid_v    = r_skid_v;
    w_skid_ctrl = r_skid_ctrl;
    w_skid_data = r_skid_data;
    if (flush) begin
      w_main_v = 1'b0;
      w_skid_v = 1'b0;
    end else if (!r_main_v || w_send) begin
      if (r_skid_v) begin
        // Oldest entry first: skid moves up, a new input refills skid.
        w_main_v    = 1'b1;
        w_main_ctrl = r_skid_ctrl;
        w_main_data = r_skid_data;
        w_skid_v    = w_accept;
        w_skid_ctrl = in_ctrl;
        w_skid_data = in_data;
      end else if (w_accept) begin
        w_main_v    = 1'b1;
        w_main_ctrl = in_ctrl;
        w_main_data = in_data;
      end else begin
        w_main_v = 1'b0;
      end
    end else if (w_accept) begin
      // Main is stalled; skid is empty here because in_ready was high.
      w_skid_v    = 1'b1;
      w_skid_ctrl = in_ctrl;
      w_skid_data = in_data;
    end
  end

  // Control/valid state registers; out_ctrl is forced to the bubble when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
      r_out_ctrl <= BUBBLE_CTRL;
      r_out_data <= '0;
    end else begin
      r_main_v   <= w_main_v;
      r_skid_v   <= w_skid_v;
      r_in_ready <= !w_skid_v;
      r_out_ctrl <= w_main_v ? w_main_ctrl : BUBBLE_CTRL;
      r_out_data <= w_main_data;
    end
  end

  // Skid payload storage.
  always_ff @(posedge clk) begin
    // NOTE: skid payload is not reset; it is only observed after r_skid_v
    // marks it valid, so a reset would add fan-out for no behavioural gain.
    r_skid_ctrl <= w_skid_ctrl;
    r_skid_data <= w_skid_data;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_v;
  assign out_ctrl  = r_out_ctrl;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: directed scenarios plus a long random run against a
// two-deep FIFO reference model of the stage.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  pipe_ctrl_t        in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  pipe_ctrl_t        out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       stall_cnt;

  logic              s_in_ready;
  logic              s_out_valid;
  pipe_ctrl_t        s_out_ctrl;
  logic [DATA_W-1:0] s_out_data;
  logic [3:0]        s_stall_cnt;

  pipe_stage_skid #(
    .CTRL_W (CTRL_W), .DATA_W (DATA_W), .BUBBLE_CTRL (BUBBLE_CTRL), .CNT_W (16)
  ) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .in_ctrl (in_ctrl), .in_data (in_data), .flush (flush),
    .out_valid (out_valid), .out_ready (out_ready), .out_ctrl (out_ctrl),
    .out_data (out_data), .stall_cnt (stall_cnt)
  );

  // Same stimulus, narrow counter, to observe saturation.
  pipe_stage_skid #(
    .CTRL_W (CTRL_W), .DATA_W (DATA_W), .BUBBLE_CTRL (BUBBLE_CTRL), .CNT_W (4)
  ) dut_sat (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (s_in_ready),
    .in_ctrl (in_ctrl), .in_data (in_data), .flush (flush),
    .out_valid (s_out_valid), .out_ready (out_ready), .out_ctrl (s_out_ctrl),
    .out_data (s_out_data), .stall_cnt (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    pipe_ctrl_t        ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            m_q[$];
  logic [DATA_W-1:0] m_last_data;
  int                m_stall;
  bit                m_known;
  bit                seen_20;
  int                n_checks;
  int                n_fails;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  task automatic compare_all();
    int exp16;
    int exp4;
    exp16 = (m_stall > 65535) ? 65535 : m_stall;
    exp4  = (m_stall > 15) ? 15 : m_stall;
    check("out_valid", out_valid, m_q.size() > 0);
    check("out_ctrl", out_ctrl, (m_q.size() > 0) ? m_q[0].ctrl : BUBBLE_CTRL);
    check("out_data", out_data, m_last_data);
    check("in_ready", in_ready, m_q.size() < 2);
    check("stall_cnt", stall_cnt, exp16);
    check("stall_cnt_sat", s_stall_cnt, exp4);
    if (out_valid && out_ctrl == 17'h00020) seen_20 = 1'b1;
  endtask

  // Called at a negedge: drive, confirm in_ready ignores the new inputs,
  // advance the model across the posedge, then compare at the next negedge.
  task automatic cycle(input logic v, input pipe_ctrl_t c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl, input logic rs);
    logic acc;
    logic snd;
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; rst = rs;
    #1;
    if (m_known) check("in_ready_comb", in_ready, m_q.size() < 2);
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_stall = 0;
      m_last_data = '0;
      m_known = 1'b1;
    end else if (fl) begin
      m_q.delete();
    end else begin
      acc = v && (m_q.size() < 2);
      snd = (m_q.size() > 0) && ordy;
      if ((m_q.size() > 0) && !ordy) m_stall++;
      if (snd) void'(m_q.pop_front());
      if (acc) m_q.push_back('{c, d});
    end
    if (m_q.size() > 0) m_last_data = m_q[0].data;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    n_checks = 0; n_fails = 0; m_known = 1'b0; m_stall = 0; seen_20 = 1'b0;
    m_last_data = '0;
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // Reset held two cycles with an input offered.
    cycle(1'b1, 17'h00aa, rnd_data(), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 17'h00ab, rnd_data(), 1'b1, 1'b0, 1'b1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall_cnt", stall_cnt, 0);

    // Streaming: one entry per cycle, one cycle latency.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, pipe_ctrl_t'(i), rnd_data(), 1'b1, 1'b0, 1'b0);
      check("stream_ctrl", out_ctrl, i);
      check("stream_in_ready", in_ready, 1);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: 0x11 arrives, then out_ready low for 5 cycles.
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 17'h00011, rnd_data(), 1'b1, 1'b0, 1'b0);
    check("bp_first", out_ctrl, 17'h00011);
    cycle(1'b1, 17'h00012, rnd_data(), 1'b0, 1'b0, 1'b0);
    begin
      logic [DATA_W-1:0] d13;
      d13 = rnd_data();
      for (int i = 0; i < 4; i++) cycle(1'b1, 17'h00013, d13, 1'b0, 1'b0, 1'b0);
      check("bp_in_ready", in_ready, 0);
      check("bp_stall5", stall_cnt, 5);
      check("bp_hold", out_ctrl, 17'h00011);
      cycle(1'b1, 17'h00013, d13, 1'b1, 1'b0, 1'b0);
      check("bp_order0", out_ctrl, 17'h00012);
      cycle(1'b1, 17'h00013, d13, 1'b1, 1'b0, 1'b0);
      check("bp_order1", out_ctrl, 17'h00013);
      check("bp_data", out_data, d13);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with both entries full while offering 0x20.
    cycle(1'b1, 17'h00021, rnd_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 17'h00022, rnd_data(), 1'b0, 1'b0, 1'b0);
    check("fl_full", in_ready, 0);
    cycle(1'b1, 17'h00020, rnd_data(), 1'b0, 1'b1, 1'b0);
    check("fl_out_valid", out_valid, 0);
    check("fl_out_ctrl", out_ctrl, BUBBLE_CTRL);
    check("fl_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("fl_dropped", seen_20, 0);

    // Saturation: one entry stalled for 20 cycles.
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 17'h00031, rnd_data(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt4", s_stall_cnt, 15);
    check("sat_cnt16", stall_cnt, 20);

    // Random traffic with rare flush and rarer reset.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(99) < 60), pipe_ctrl_t'($urandom()), rnd_data(),
            ($urandom_range(99) < 70), ($urandom_range(63) == 0),
            ($urandom_range(1999) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
